// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// Holds the state encoding, control bundle and NOP constants.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_bubble;
        logic ex_mem_stall;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE     = 7'b000_0000;
    localparam ctrl_t CTRL_FREEZE   = 7'b110_1011;
    localparam ctrl_t CTRL_LOAD_USE = 7'b110_0100;
    localparam ctrl_t CTRL_REDIRECT = 7'b001_0000;
    localparam ctrl_t CTRL_FMISS    = 7'b101_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator between the ID sources and the EX destination.
// x0 is never a hazard source.
import pipe_hazard_ctrl_pkg::*;

module hazard_detect #(
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs1_used,
    input  logic          rs2_used,
    input  logic          rd_wen,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_is_load,
    output logic          load_use
);

    logic rd_live;
    logic rs1_match;
    logic rs2_match;

    assign rd_live   = rd_wen && (rd_addr != '0);
    assign rs1_match = rd_live && rs1_used && (rs1_addr == rd_addr);
    assign rs2_match = rd_live && rs2_used && (rs2_addr == rd_addr);
    assign load_use  = rd_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline.
// Generates stage hold/flush/bubble controls and stall/flush counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_W          = 32,
    parameter int FLUSH_CNT_W    = 16,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
    input  logic                      ex_is_load,
    input  logic                      id_redirect,
    input  logic                      imem_valid,
    input  logic                      mem_req_valid,
    input  logic                      mem_resp_ready,
    input  logic                      wb_ebreak,
    output logic                      pc_stall,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_stall,
    output logic                      id_ex_bubble,
    output logic                      ex_mem_stall,
    output logic                      mem_wb_bubble,
    output logic                      halted,
    output logic                      mem_timeout,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [FLUSH_CNT_W-1:0]    flush_count
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t         state;
    state_t         state_n;
    logic [WW-1:0]  wait_cnt;
    logic [WW-1:0]  wait_n;
    logic [WW-1:0]  wait_inc;
    logic           rst_d;
    logic           blank;
    logic           load_use;
    logic           flush_inc;
    ctrl_t          ctrl;

    hazard_detect #(
        .AW(REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .rs1_addr   (id_rs1_addr),
        .rs2_addr   (id_rs2_addr),
        .rs1_used   (id_rs1_used),
        .rs2_used   (id_rs2_used),
        .rd_wen     (ex_reg_wen),
        .rd_addr    (ex_reg_waddr),
        .rd_is_load (ex_is_load),
        .load_use   (load_use)
    );

    // Controls stay quiet for the reset cycle and the one after it.
    assign blank    = rst || rst_d;
    assign wait_inc = wait_cnt + WW'(1);

    always_comb begin
        ctrl      = CTRL_NONE;
        state_n   = state;
        wait_n    = wait_cnt;
        flush_inc = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mem_req_valid && !mem_resp_ready) begin
                    ctrl    = CTRL_FREEZE;
                    state_n = ST_MEM_WAIT;
                    wait_n  = WW'(1);
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end else if (id_redirect) begin
                    ctrl      = CTRL_REDIRECT;
                    flush_inc = 1'b1;
                end else if (!imem_valid) begin
                    ctrl = CTRL_FMISS;
                end
                if (wb_ebreak) begin
                    state_n = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (mem_resp_ready) begin
                    state_n = ST_RUN;
                    wait_n  = '0;
                end else if (wait_inc >= WW'(MEM_TIMEOUT)) begin
                    state_n = ST_ERR;
                    wait_n  = wait_inc;
                end else begin
                    wait_n = wait_inc;
                end
            end
            ST_HALT: ctrl = CTRL_FREEZE;
            ST_ERR:  ctrl = CTRL_FREEZE;
            default: ctrl = CTRL_NONE;
        endcase
        if (blank) begin
            ctrl      = CTRL_NONE;
            flush_inc = 1'b0;
            state_n   = ST_RUN;
            wait_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            rst_d        <= 1'b1;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            rst_d    <= 1'b0;
            if (ctrl.pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc && (flush_count != '1)) begin
                flush_count <= flush_count + FLUSH_CNT_W'(1);
            end
        end
    end

    assign pc_stall      = ctrl.pc_stall;
    assign if_id_stall   = ctrl.if_id_stall;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_stall   = ctrl.id_ex_stall;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_stall  = ctrl.ex_mem_stall;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign halted        = (state == ST_HALT) && !blank;
    assign mem_timeout   = (state == ST_ERR) && !blank;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard queue.
// Small counter widths and a short timeout expose saturation edges.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int FW = 2;

    localparam logic [6:0] C0 = 7'b000_0000;
    localparam logic [6:0] FZ = 7'b110_1011;
    localparam logic [6:0] LU = 7'b110_0100;
    localparam logic [6:0] RD = 7'b001_0000;
    localparam logic [6:0] FM = 7'b101_0000;

    typedef struct packed {
        logic [6:0] ctrl;
        logic       h;
        logic       t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1, rs2, ewaddr;
    logic          u1, u2, ewen, eload, redir, ival;
    logic          mreq, mrdy, ebrk;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic          id_ex_bubble, ex_mem_stall, mem_wb_bubble;
    logic          halted, mem_timeout;
    logic [CW-1:0] stall_cycles;
    logic [FW-1:0] flush_count;
    logic [6:0]    ctrl_o;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            step = 0;
    logic [CW-1:0] exp_sc = '0;
    logic [FW-1:0] exp_fc = '0;

    always #5 clk = ~clk;

    assign ctrl_o = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                     id_ex_bubble, ex_mem_stall, mem_wb_bubble};

    pipe_hazard_ctrl #(
        .REG_ADDR_WIDTH(AW),
        .CNT_W(CW),
        .FLUSH_CNT_W(FW),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(rs1), .id_rs2_addr(rs2),
        .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_reg_wen(ewen), .ex_reg_waddr(ewaddr), .ex_is_load(eload),
        .id_redirect(redir), .imem_valid(ival),
        .mem_req_valid(mreq), .mem_resp_ready(mrdy), .wb_ebreak(ebrk),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    task automatic idle();
        rs1 = '0; rs2 = '0; u1 = 0; u2 = 0;
        ewen = 0; ewaddr = '0; eload = 0;
        redir = 0; ival = 1; mreq = 0; mrdy = 0; ebrk = 0;
    endtask

    task automatic load_hit(input logic [AW-1:0] rd);
        eload = 1; ewen = 1; ewaddr = rd;
        u2 = 1; rs2 = rd; u1 = 1; rs1 = 5'd9;
    endtask

    task automatic chk(input logic [6:0] c, input logic h, input logic t);
        exp_t e;
        exp_t g;
        e.ctrl = c; e.h = h; e.t = t;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        total++;
        assert (ctrl_o === g.ctrl) else begin
            bad++;
            $error("FAIL ctrl step=%0d got=%b exp=%b", step, ctrl_o, g.ctrl);
        end
        total++;
        assert (halted === g.h) else begin
            bad++;
            $error("FAIL halted step=%0d got=%b exp=%b", step, halted, g.h);
        end
        total++;
        assert (mem_timeout === g.t) else begin
            bad++;
            $error("FAIL timeout step=%0d got=%b exp=%b", step, mem_timeout, g.t);
        end
        total++;
        assert (stall_cycles === exp_sc) else begin
            bad++;
            $error("FAIL stall_cycles step=%0d got=%0d exp=%0d", step, stall_cycles, exp_sc);
        end
        total++;
        assert (flush_count === exp_fc) else begin
            bad++;
            $error("FAIL flush_count step=%0d got=%0d exp=%0d", step, flush_count, exp_fc);
        end
        if (g.ctrl[6] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
        if (g.ctrl[4] && !g.ctrl[6] && exp_fc != '1) exp_fc = exp_fc + 1'b1;
        @(posedge clk);
        #1;
        step++;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        exp_sc = '0;
        exp_fc = '0;
        load_hit(5'd7);
        ival = 0;
        redir = 1;
        chk(C0, 0, 0);
        rst = 0;
        chk(C0, 0, 0);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        do_reset();
        chk(C0, 0, 0);

        load_hit(5'd5);
        chk(LU, 0, 0);
        idle();
        chk(C0, 0, 0);

        load_hit(5'd0);
        chk(C0, 0, 0);
        idle();

        redir = 1;
        chk(RD, 0, 0);
        idle();
        chk(C0, 0, 0);

        load_hit(5'd5);
        redir = 1;
        chk(LU, 0, 0);
        idle();
        redir = 1;
        chk(RD, 0, 0);
        idle();

        ival = 0;
        chk(FM, 0, 0);
        load_hit(5'd5);
        ival = 0;
        chk(LU, 0, 0);
        idle();

        mreq = 1; mrdy = 1;
        chk(C0, 0, 0);
        mrdy = 0;
        chk(FZ, 0, 0);
        mreq = 0; redir = 1;
        chk(FZ, 0, 0);
        chk(FZ, 0, 0);
        mrdy = 1;
        chk(FZ, 0, 0);
        idle();
        chk(C0, 0, 0);

        repeat (3) begin
            redir = 1;
            chk(RD, 0, 0);
        end
        idle();

        mreq = 1;
        chk(FZ, 0, 0);
        chk(FZ, 0, 0);
        chk(FZ, 0, 0);
        chk(FZ, 0, 0);
        mreq = 0;
        repeat (5) begin
            redir = ~redir;
            chk(FZ, 0, 1);
        end
        mrdy = 1;
        chk(FZ, 0, 1);
        idle();
        do_reset();
        chk(C0, 0, 0);

        ebrk = 1;
        chk(C0, 0, 0);
        ebrk = 0;
        chk(FZ, 1, 0);
        redir = 1; ival = 0;
        chk(FZ, 1, 0);
        redir = 0; ival = 1;
        chk(FZ, 1, 0);
        do_reset();
        load_hit(5'd3);
        chk(LU, 0, 0);
        idle();
        chk(C0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards, branch/jump redirects, fetch misses, data-memory wait states, memory timeouts and ebreak halt.
- Drives per-stage stall/flush/bubble controls into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Keeps performance counters for stall and flush cycles.
- Sits beside the top-level pipeline; all stage registers take their hold/clear from it.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
CNT_W, 32, width of the stall-cycle counter
FLUSH_CNT_W, 16, width of the flush counter
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before the timeout error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_addr  in  REG_ADDR_WIDTH  ID source register 1
id_rs2_addr  in  REG_ADDR_WIDTH  ID source register 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_reg_wen  in  1  EX instruction writes rd
ex_reg_waddr  in  REG_ADDR_WIDTH  EX rd
ex_is_load  in  1  EX instruction is a load (rd_buf_flag != 0)
id_redirect  in  1  ID resolved a taken branch/jump (next_pc != pc+4)
imem_valid  in  1  instruction fetch data valid this cycle
mem_req_valid  in  1  MEM stage issues a data-memory access
mem_resp_ready  in  1  data memory completes the access this cycle
wb_ebreak  in  1  ebreak retiring in WB
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_bubble  out  1  load NOP into MEM/WB
halted  out  1  sticky ebreak halt
mem_timeout  out  1  sticky memory-timeout error
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
flush_count  out  FLUSH_CNT_W  saturating count of if_id_flush pulses

Behaviour:
- Clock is clk; reset rst is synchronous and active-high.
- On reset:
  - state = RUN; wait counter, stall_cycles and flush_count = 0; halted = 0 and mem_timeout = 0.
  - Every control output is 0 in the reset cycle and the cycle after.
  - Reset in any state, including MEM_WAIT, HALT and ERR, returns to RUN at the next edge.
- States:
  - RUN: normal operation.
  - MEM_WAIT: data access outstanding.
  - HALT: ebreak retired.
  - ERR: memory timeout.
- Control outputs are combinational from state and inputs (zero latency). Counters and state are registered.
- Priority within RUN, highest first:
  1. wb_ebreak: next state HALT. The current cycle still completes normally, so the ebreak retires.
  2. mem_req_valid && !mem_resp_ready: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble; next state MEM_WAIT; wait counter = 1.
  3. Load-use: ex_is_load && ex_reg_wen && ex_reg_waddr != 0 && ((id_rs1_used && id_rs1_addr == ex_reg_waddr) || (id_rs2_used && id_rs2_addr == ex_reg_waddr)).
     - Assert pc_stall, if_id_stall and id_ex_bubble for exactly that cycle.
     - id_redirect is ignored that cycle; the instruction is re-evaluated next cycle.
  4. id_redirect: assert if_id_flush for one cycle; flush_count += 1.
  5. !imem_valid: assert pc_stall and if_id_flush. flush_count is not incremented for fetch misses.
- MEM_WAIT:
  - Freeze set (pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble) is held every cycle.
  - mem_resp_ready = 1: release the freeze that same cycle; return to RUN.
  - Wait counter reaches MEM_TIMEOUT without a response: set mem_timeout; go to ERR.
  - wb_ebreak cannot occur here because WB receives a bubble.
- HALT: halted = 1 and the freeze set is held permanently. The state is absorbing until rst.
- ERR: mem_timeout = 1 and the freeze set is held. The state is absorbing until rst.
- stall_cycles increments on every cycle with pc_stall = 1, in any state, and saturates at all-ones.
- flush_count saturates at all-ones.
- Register x0 never causes a hazard.
- Simultaneous load-use and fetch miss: the load-use outputs win; if_id_flush = 0.

Decomposition:
- Shared package holds the state encoding (RUN, MEM_WAIT, HALT, ERR; 2 bits) and REG_ADDR_WIDTH / NOP-injection constants shared with the stage registers.
- One sub-module is natural: hazard_detect, a combinational load-use comparator (rs/rd match with x0 exclusion) that is reusable by the forwarding logic.

Test Plan:
- Load-use: EX load with rd = 5, ID reads rs2 = 5 → pc_stall = if_id_stall = id_ex_bubble = 1 for exactly 1 cycle; stall_cycles = 1. The same case with rd = 0 → no stall.
- Redirect: id_redirect pulse with no hazard → if_id_flush = 1 for 1 cycle; flush_count 0 → 1. Redirect coincident with load-use → if_id_flush = 0; the redirect is honoured the following cycle.
- Memory wait: mem_req_valid = 1 with mem_resp_ready low for 3 cycles, then high → freeze set held 4 cycles, released in the response cycle; state back to RUN; stall_cycles = 4.
- Timeout: MEM_TIMEOUT = 4, no response → mem_timeout = 1 after the 4th wait cycle; the freeze persists; rst → all outputs 0 and state RUN.
- Halt: wb_ebreak = 1 → halted = 1 from the next cycle, pc_stall held; later id_redirect and imem_valid toggles have no effect until rst.
- Saturation: preload via a long MEM_WAIT with CNT_W = 4 → stall_cycles stops at 15.
